// File: rtl/mac16_mul32_seq_pkg.sv
// Shared constants, state encoding and operand helpers for the mac16_mul32_seq sequencer.
// Defining MAC16_SEQ_PIPE_EN widens the step counter for a DSP with a registered product.
package mac16_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

`ifdef MAC16_SEQ_PIPE_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 2;
`endif

  // Bit position at which each of the four 16x16 partial products lands.
  localparam logic [5:0] SHIFT_TABLE [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

  function automatic logic [15:0] pair_a(input logic [31:0] a, input logic [1:0] k);
    return k[0] ? a[31:16] : a[15:0];
  endfunction

  function automatic logic [15:0] pair_b(input logic [31:0] b, input logic [1:0] k);
    return k[1] ? b[31:16] : b[15:0];
  endfunction

  function automatic logic [63:0] shifted_product(input logic [31:0] p, input logic [1:0] k);
    return {32'd0, p} << SHIFT_TABLE[k];
  endfunction

endpackage

// File: rtl/mac16_mul32_seq_if.sv
// Request/response handshake plus DSP operand/product bus of the mac16_mul32_seq sequencer.
// The master modport is the sequencer view; the slave modport is the surrounding environment.
interface mac16_mul32_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        mac_ce;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_o;

  modport master (
    input  req_valid, req_op, req_a, req_b, resp_ready, mac_o,
    output req_ready, resp_valid, resp_data, mac_ce, mac_a, mac_b
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, resp_ready, mac_o,
    input  req_ready, resp_valid, resp_data, mac_ce, mac_a, mac_b
  );
endinterface

// File: rtl/mac16_mul32_seq.sv
// 32x32 multiplier built from four passes through an external unsigned 16x16 DSP multiply.
// MAC16_SEQ_PIPE_EN selects a DSP whose product arrives one cycle after its operands.
module mac16_mul32_seq
  import mac16_seq_pkg::*;
(
  input logic              clock,
  input logic              IRSTTOP,
  mac16_mul32_seq_if.master bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;
  logic [63:0]      acc;
  logic [31:0]      hi_fixed;
  logic             acc_en;
  logic [1:0]       acc_pair;
  logic             last_step;
  logic             drive_next;
  logic [1:0]       next_pair;

  // The unsigned partial products treat negative operands as 2^32 + x; remove that excess.
  always_comb begin
    hi_fixed = acc[63:32];
    if ((op_q == OP_MULH || op_q == OP_MULHSU) && a_q[31])
      hi_fixed = hi_fixed - b_q;
    if (op_q == OP_MULH && b_q[31])
      hi_fixed = hi_fixed - a_q;
  end

`ifdef MAC16_SEQ_PIPE_EN
  assign acc_en     = (cnt != '0);
  assign acc_pair   = 2'(cnt - 3'd1);
  assign last_step  = (cnt == 3'd4);
  assign drive_next = (cnt < 3'd3);
`else
  assign acc_en     = 1'b1;
  assign acc_pair   = cnt;
  assign last_step  = (cnt == 2'd3);
  assign drive_next = !last_step;
`endif
  assign next_pair = 2'(cnt + 1'b1);

  // Operands are registered one step ahead so the DSP sees pair k during step k.
  always_ff @(posedge clock or posedge IRSTTOP) begin
    if (IRSTTOP) begin
      state          <= IDLE;
      cnt            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= OP_MUL;
      acc            <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.mac_ce     <= 1'b0;
      bus.mac_a      <= '0;
      bus.mac_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            op_q          <= bus.req_op;
            acc           <= '0;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.mac_ce    <= 1'b1;
            bus.mac_a     <= pair_a(bus.req_a, 2'd0);
            bus.mac_b     <= pair_b(bus.req_b, 2'd0);
            state         <= MUL;
          end
        end
        MUL: begin
          if (acc_en)
            acc <= acc + shifted_product(bus.mac_o, acc_pair);
          cnt <= cnt + 1'b1;
          if (drive_next) begin
            bus.mac_a <= pair_a(a_q, next_pair);
            bus.mac_b <= pair_b(b_q, next_pair);
          end else begin
            bus.mac_a <= '0;
            bus.mac_b <= '0;
          end
          if (last_step) begin
            bus.mac_ce <= 1'b0;
            state      <= FIX;
          end
        end
        FIX: begin
          acc[63:32]     <= hi_fixed;
          bus.resp_valid <= 1'b1;
          bus.resp_data  <= (op_q == OP_MUL) ? acc[31:0] : hi_fixed;
          state          <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac16_mul32_seq.sv
// Directed and random self-checking bench for mac16_mul32_seq, with a behavioural 16x16 DSP.
// The DSP model and expected latency follow MAC16_SEQ_PIPE_EN.
module tb_mac16_mul32_seq;
  import mac16_seq_pkg::*;

`ifdef MAC16_SEQ_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic clock = 1'b0;
  logic IRSTTOP;
  int   checks = 0;
  int   errors = 0;

  mac16_mul32_seq_if bus();

  mac16_mul32_seq dut (
    .clock  (clock),
    .IRSTTOP(IRSTTOP),
    .bus    (bus)
  );

  always #5 clock = ~clock;

`ifdef MAC16_SEQ_PIPE_EN
  logic [31:0] prod_q = '0;
  always_ff @(posedge clock)
    if (bus.mac_ce) prod_q <= {16'd0, bus.mac_a} * {16'd0, bus.mac_b};
  assign bus.mac_o = prod_q;
`else
  assign bus.mac_o = {16'd0, bus.mac_a} * {16'd0, bus.mac_b};
`endif

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction with resp_ready held high; reports result and accept-to-valid edges.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] data, output int lat);
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    data = bus.resp_data;
    @(negedge clock);
    checkOutput({tag, "_done"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          lat;

    bus.req_valid  = 1'b0;
    bus.req_op     = OP_MUL;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    IRSTTOP        = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_mac_ce", 32'(bus.mac_ce), 32'd0);
    checkOutput("rst_mac_ab", {bus.mac_a, bus.mac_b}, 32'd0);
    IRSTTOP = 1'b0;

    applyStimulus("mulhu_ones", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
    checkOutput("mulhu_ones", data, 32'hFFFFFFFE);
    checkOutput("latency", 32'(lat), 32'(LAT));
    applyStimulus("mul_ones", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
    checkOutput("mul_ones", data, 32'h00000001);
    applyStimulus("mulh_m1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
    checkOutput("mulh_m1", data, 32'h00000000);
    applyStimulus("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, data, lat);
    checkOutput("mulh_min", data, 32'h40000000);
    applyStimulus("mulhsu_ones", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
    checkOutput("mulhsu_ones", data, 32'hFFFFFFFF);
    applyStimulus("mulhu_2p16", OP_MULHU, 32'h00010000, 32'h00010000, data, lat);
    checkOutput("mulhu_2p16", data, 32'h00000001);
    applyStimulus("mul_2p16", OP_MUL, 32'h00010000, 32'h00010000, data, lat);
    checkOutput("mul_2p16", data, 32'h00000000);
    applyStimulus("mul_neg", OP_MUL, 32'd7, 32'hFFFFFFFD, data, lat);
    checkOutput("mul_neg", data, 32'hFFFFFFEB);
    applyStimulus("mulh_neg", OP_MULH, 32'd7, 32'hFFFFFFFD, data, lat);
    checkOutput("mulh_neg", data, 32'hFFFFFFFF);

    // Backpressure: hold the response while a second request is offered.
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_MULHU;
    bus.req_a      = 32'h00010000;
    bus.req_b      = 32'h00010000;
    bus.resp_ready = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("bp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("bp_data", bus.resp_data, 32'h00000001);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MUL;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd6;
    repeat (3) begin
      @(negedge clock);
      checkOutput("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("bp_hold_data", bus.resp_data, 32'h00000001);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    checkOutput("bp_release", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    repeat (8) @(negedge clock);
    checkOutput("bp_ignored", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    applyStimulus("bp_next", OP_MUL, 32'd5, 32'd6, data, lat);
    checkOutput("bp_next", data, 32'd30);

    // Reset in the middle of MUL step 2.
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_MULHU;
    bus.req_a      = 32'hFFFFFFFF;
    bus.req_b      = 32'hFFFFFFFF;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("mid_mac_ce", 32'(bus.mac_ce), 32'd1);
    checkOutput("mid_mac_ab", {bus.mac_a, bus.mac_b}, 32'hFFFFFFFF);
    IRSTTOP = 1'b1;
    #1;
    checkOutput("abort_outputs", {bus.mac_a, 12'd0, bus.req_ready, bus.resp_valid, bus.mac_ce,
                                  bus.mac_b[0]}, 32'h00000008);
    @(negedge clock);
    IRSTTOP = 1'b0;
    checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("abort_resp", {31'd0, bus.resp_valid} | bus.resp_data, 32'd0);
    checkOutput("abort_mac", {bus.mac_a, bus.mac_b} | {31'd0, bus.mac_ce}, 32'd0);
    applyStimulus("post_abort", OP_MULHU, 32'h00010000, 32'h00010000, data, lat);
    checkOutput("post_abort", data, 32'h00000001);

    for (int i = 0; i < 100; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb, data, lat);
      checkOutput($sformatf("rand%0d_op%0d", i, rop), data, ref_mul(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
